// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   UART transmitter with a small byte FIFO in front of the serializer.
//   Frames are DATA_BITS data bits LSB-first, an optional odd/even parity bit
//   and one or two stop bits. Queued bytes go out back-to-back: the next start
//   bit follows the last stop bit with no idle gap.
//
// Ports
//   i_Clock       system clock, rising edge
//   i_Rst_L       synchronous reset, active-low
//   i_Tx_DV       write strobe; byte accepted when o_Tx_Ready=1
//   i_Tx_Byte     byte to queue (DATA_BITS wide)
//   o_Tx_Ready    FIFO not full
//   o_Fifo_Count  entries queued, not counting the frame on the line
//   o_Overflow    1-cycle pulse: write while full, byte dropped
//   o_Tx_Active   high from start bit through last stop bit
//   o_Tx_Serial   UART line, idle high
//   o_Tx_Done     1-cycle pulse at the end of each frame
//
// All outputs come straight from flops.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line high, waiting for a queued byte
// S_START  | start bit (line low)
// S_DATA   | data bit r_bit_idx, LSB first
// S_PARITY | parity bit (only when PARITY != 0)
// S_STOP   | stop bit r_bit_idx; last cycle pops the next byte if any
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                              i_Clock,
   input  logic                              i_Rst_L,
   input  logic                              i_Tx_DV,
   input  logic [DATA_BITS-1:0]              i_Tx_Byte,
   output logic                              o_Tx_Ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_Fifo_Count,
   output logic                              o_Overflow,
   output logic                              o_Tx_Active,
   output logic                              o_Tx_Serial,
   output logic                              o_Tx_Done
);

   // ------------------------------------------------------------------
   // Parameter checks
   // ------------------------------------------------------------------
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be in 5..8");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
   end

   // ------------------------------------------------------------------
   // Local constants
   // ------------------------------------------------------------------
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
   // Bit index covers data bits 0..7 and stop bits 0..1.
   localparam int IDX_W = 3;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
   localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------
   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr;
   logic [PTR_W-1:0]     r_rd_ptr;
   logic [LVL_W-1:0]     r_count;
   logic                 r_ready;
   logic                 r_overflow;

   logic                 w_full;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_fifo_has;
   logic [LVL_W-1:0]     w_count_nxt;
   logic [DATA_BITS-1:0] w_head;

   // Full is judged on the pre-edge count, so a write to a full FIFO is
   // dropped even if the serializer pops at the same edge.
   assign w_full     = (r_count == LVL_FULL);
   assign w_push     = i_Tx_DV && !w_full;
   assign w_fifo_has = (r_count != '0);
   assign w_head     = r_mem[r_rd_ptr];

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + LVL_W'(1);
         2'b01:   w_count_nxt = r_count - LVL_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_L) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_ready    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count    <= w_count_nxt;
         r_ready    <= (w_count_nxt != LVL_FULL);
         r_overflow <= i_Tx_DV && w_full;
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge i_Clock) begin
      if (w_push) r_mem[r_wr_ptr] <= i_Tx_Byte;
   end

   // ------------------------------------------------------------------
   // Serializer FSM
   // ------------------------------------------------------------------
   state_t               r_state;
   logic [CNT_W-1:0]     r_clk_cnt;
   logic [IDX_W-1:0]     r_bit_idx;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_serial;
   logic                 r_active;
   logic                 r_done;

   state_t               w_state_nxt;
   logic [CNT_W-1:0]     w_clk_cnt_nxt;
   logic [IDX_W-1:0]     w_bit_idx_nxt;
   logic [DATA_BITS-1:0] w_data_nxt;
   logic                 w_cnt_tc;
   logic                 w_frame_end;
   logic                 w_parity_bit;
   logic                 w_serial_nxt;
   logic                 w_active_nxt;
   logic                 w_done_nxt;

   assign w_cnt_tc     = (r_clk_cnt == CNT_LAST);
   assign w_frame_end  = (r_state == S_STOP) && w_cnt_tc && (r_bit_idx == STOP_LAST);
   // PARITY==2 is even parity; otherwise odd (only used when PARITY != 0).
   assign w_parity_bit = (PARITY == 2) ? (^r_data) : (~^r_data);

   // State register
   always_ff @(posedge i_Clock) begin
      if (!i_Rst_L) begin
         r_state   <= S_IDLE;
         r_clk_cnt <= '0;
         r_bit_idx <= '0;
         r_data    <= '0;
         r_serial  <= 1'b1;
         r_active  <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_clk_cnt <= w_clk_cnt_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_data    <= w_data_nxt;
         r_serial  <= w_serial_nxt;
         r_active  <= w_active_nxt;
         r_done    <= w_done_nxt;
      end
   end

   // Next-state logic, including the pop decision and counter updates
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_fifo_has) begin
               w_pop       = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_cnt_tc) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            if (w_cnt_tc && (r_bit_idx == DATA_LAST))
               w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            if (w_cnt_tc) w_state_nxt = S_STOP;
         end
         S_STOP: begin
            if (w_frame_end) begin
               if (w_fifo_has) begin
                  // Chain straight into the next frame's start bit.
                  w_pop       = 1'b1;
                  w_state_nxt = S_START;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Bit-period counter runs only inside a frame and wraps every bit.
      if (r_state == S_IDLE || w_cnt_tc) w_clk_cnt_nxt = '0;
      else                               w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);

      // Bit index restarts on every state change; within DATA/STOP it
      // advances once per bit period.
      if (w_state_nxt != r_state) w_bit_idx_nxt = '0;
      else if (w_cnt_tc)          w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
      else                        w_bit_idx_nxt = r_bit_idx;

      w_data_nxt = w_pop ? w_head : r_data;
   end

   // Output logic: values for the output flops, taken from the next state
   // so the line changes on the same edge as the state.
   always_comb begin
      w_serial_nxt = 1'b1;
      case (w_state_nxt)
         S_START:  w_serial_nxt = 1'b0;
         S_DATA:   w_serial_nxt = w_data_nxt[w_bit_idx_nxt];
         S_PARITY: w_serial_nxt = w_parity_bit;
         default:  w_serial_nxt = 1'b1;
      endcase
      w_active_nxt = (w_state_nxt != S_IDLE);
      w_done_nxt   = w_frame_end;
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign o_Tx_Ready   = r_ready;
   assign o_Fifo_Count = r_count;
   assign o_Overflow   = r_overflow;
   assign o_Tx_Active  = r_active;
   assign o_Tx_Serial  = r_serial;
   assign o_Tx_Done    = r_done;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Three transmitters (8N1, 7E2, 8O1) at 4 clocks/bit with a 4-entry FIFO,
//   driven by directed and random writes. A frame-level model (byte queue plus
//   time-into-frame) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_l;
   logic [2:0] dv;
   logic [7:0] tb_byte [3];
   logic [2:0] ready, ovf, active, ser, done;
   logic [2:0] cnt [3];

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                  .FIFO_DEPTH(DEPTH)) dut_8n1 (
      .i_Clock(clk), .i_Rst_L(rst_l), .i_Tx_DV(dv[0]), .i_Tx_Byte(tb_byte[0]),
      .o_Tx_Ready(ready[0]), .o_Fifo_Count(cnt[0]), .o_Overflow(ovf[0]),
      .o_Tx_Active(active[0]), .o_Tx_Serial(ser[0]), .o_Tx_Done(done[0]));

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                  .FIFO_DEPTH(DEPTH)) dut_7e2 (
      .i_Clock(clk), .i_Rst_L(rst_l), .i_Tx_DV(dv[1]), .i_Tx_Byte(tb_byte[1][6:0]),
      .o_Tx_Ready(ready[1]), .o_Fifo_Count(cnt[1]), .o_Overflow(ovf[1]),
      .o_Tx_Active(active[1]), .o_Tx_Serial(ser[1]), .o_Tx_Done(done[1]));

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                  .FIFO_DEPTH(DEPTH)) dut_8o1 (
      .i_Clock(clk), .i_Rst_L(rst_l), .i_Tx_DV(dv[2]), .i_Tx_Byte(tb_byte[2]),
      .o_Tx_Ready(ready[2]), .o_Fifo_Count(cnt[2]), .o_Overflow(ovf[2]),
      .o_Tx_Active(active[2]), .o_Tx_Serial(ser[2]), .o_Tx_Done(done[2]));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Frame configuration per instance
   function automatic int db(int d);  return (d == 1) ? 7 : 8; endfunction
   function automatic int par(int d); return (d == 0) ? 0 : ((d == 1) ? 2 : 1); endfunction
   function automatic int sb(int d);  return (d == 1) ? 2 : 1; endfunction
   function automatic int flen(int d);
      return CPB * (1 + db(d) + ((par(d) != 0) ? 1 : 0) + sb(d));
   endfunction

   // Expected line level t cycles into a frame carrying byte b.
   function automatic logic exp_bit(int d, int b, int t);
      int k;
      int ones;
      k = t / CPB;
      if (k == 0) return 1'b0;
      if (k <= db(d)) return b[k-1];
      if (par(d) != 0 && k == db(d) + 1) begin
         ones = $countones(b);
         return ((ones % 2) == 1) == (par(d) == 2);
      end
      return 1'b1;
   endfunction

   function automatic void chk(string tag, int d, logic [7:0] got, logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s dut=%0d cyc=%0d got=%0h exp=%0h", tag, d, cyc, got, exp);
      end
   endfunction

   // Reference model state
   int   m_buf [3][8];
   int   m_head [3];
   int   m_n [3];
   int   m_busy [3];
   int   m_t [3];
   int   m_cur [3];
   int   m_frames [3];
   logic m_done [3];
   logic m_ovf [3];

   int   obs_done [3];
   int   st [8];
   int   n_st;
   logic prev_act0;

   task automatic model_edge();
      int  pre_n;
      bit  full;
      for (int d = 0; d < 3; d++) begin
         if (!rst_l) begin
            m_n[d] = 0; m_head[d] = 0; m_busy[d] = 0; m_t[d] = 0;
            m_done[d] = 1'b0; m_ovf[d] = 1'b0;
         end else begin
            pre_n = m_n[d];
            full  = (pre_n >= DEPTH);
            m_ovf[d]  = dv[d] && full;
            m_done[d] = 1'b0;
            if (m_busy[d] != 0) begin
               m_t[d]++;
               if (m_t[d] == flen(d)) begin
                  m_done[d] = 1'b1;
                  m_busy[d] = 0;
                  m_frames[d]++;
               end
            end
            if (m_busy[d] == 0 && pre_n > 0) begin
               m_cur[d]  = m_buf[d][m_head[d]];
               m_head[d] = (m_head[d] + 1) % 8;
               m_n[d]--;
               m_busy[d] = 1;
               m_t[d]    = 0;
            end
            if (dv[d] && !full) begin
               m_buf[d][(m_head[d] + m_n[d]) % 8] = int'(tb_byte[d]) & ((1 << db(d)) - 1);
               m_n[d]++;
            end
         end
      end
   endtask

   task automatic compare();
      logic exp_ser;
      for (int d = 0; d < 3; d++) begin
         exp_ser = (m_busy[d] != 0) ? exp_bit(d, m_cur[d], m_t[d]) : 1'b1;
         chk("serial", d, {7'd0, ser[d]},    {7'd0, exp_ser});
         chk("active", d, {7'd0, active[d]}, {7'd0, (m_busy[d] != 0)});
         chk("done",   d, {7'd0, done[d]},   {7'd0, m_done[d]});
         chk("ovf",    d, {7'd0, ovf[d]},    {7'd0, m_ovf[d]});
         chk("ready",  d, {7'd0, ready[d]},  {7'd0, (m_n[d] < DEPTH)});
         chk("count",  d, {5'd0, cnt[d]},    8'(m_n[d]));
         if (done[d] === 1'b1) obs_done[d]++;
      end
      // Start-bit cycles of the 8N1 instance: first cycle of a frame.
      if (active[0] === 1'b1 && ser[0] === 1'b0 &&
          (prev_act0 !== 1'b1 || done[0] === 1'b1) && n_st < 8) begin
         st[n_st] = cyc;
         n_st++;
      end
      prev_act0 = active[0];
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cyc++;
      compare();
      dv = '0;
   endtask

   task automatic run(int n);
      repeat (n) step();
   endtask

   task automatic push(int d, logic [7:0] b);
      tb_byte[d] = b;
      dv[d]      = 1'b1;
   endtask

   int b0, b1, b2;
   int burst [3];

   initial begin
      rst_l = 1'b0;
      dv    = '0;
      for (int d = 0; d < 3; d++) begin
         tb_byte[d] = '0; m_frames[d] = 0; obs_done[d] = 0; burst[d] = 0;
         m_n[d] = 0; m_head[d] = 0; m_busy[d] = 0; m_t[d] = 0; m_cur[d] = 0;
         m_done[d] = 1'b0; m_ovf[d] = 1'b0;
      end
      n_st = 0;
      prev_act0 = 1'b0;

      // Reset state
      step(); step();
      for (int d = 0; d < 3; d++) begin
         chk("rst_serial", d, {7'd0, ser[d]},    8'd1);
         chk("rst_ready",  d, {7'd0, ready[d]},  8'd1);
         chk("rst_active", d, {7'd0, active[d]}, 8'd0);
         chk("rst_count",  d, {5'd0, cnt[d]},    8'd0);
      end
      rst_l = 1'b1;
      run(3);

      // 8N1 0xA5, 7E2 0x35, 8O1 0x00 then 0xFF
      b0 = obs_done[0]; b1 = obs_done[1]; b2 = obs_done[2];
      push(0, 8'hA5); push(1, 8'h35); push(2, 8'h00);
      step();
      push(2, 8'hFF);
      step();
      chk("lat_start_line", 0, {7'd0, ser[0]},    8'd0);
      chk("lat_active",     0, {7'd0, active[0]}, 8'd1);
      run(100);
      chk("frames_a5",   0, 8'(obs_done[0] - b0), 8'd1);
      chk("frames_7e2",  1, 8'(obs_done[1] - b1), 8'd1);
      chk("frames_8o1",  2, 8'(obs_done[2] - b2), 8'd2);

      // Three consecutive writes: back-to-back frames 40 cycles apart
      b0 = obs_done[0]; n_st = 0;
      push(0, 8'h11); step();
      push(0, 8'h22); step();
      push(0, 8'h33); step();
      run(130);
      chk("b2b_starts", 0, 8'(n_st), 8'd3);
      chk("b2b_gap1",   0, 8'(st[1] - st[0]), 8'd40);
      chk("b2b_gap2",   0, 8'(st[2] - st[1]), 8'd40);
      chk("b2b_frames", 0, 8'(obs_done[0] - b0), 8'd3);

      // Six consecutive writes: one popped, four queued, sixth dropped
      b0 = obs_done[0];
      for (int i = 0; i < 6; i++) begin
         push(0, 8'(8'h40 + i));
         step();
      end
      chk("full_ready", 0, {7'd0, ready[0]}, 8'd0);
      chk("full_count", 0, {5'd0, cnt[0]},   8'd4);
      chk("full_ovf",   0, {7'd0, ovf[0]},   8'd1);
      run(210);
      chk("full_frames", 0, 8'(obs_done[0] - b0), 8'd5);

      // Reset mid-DATA with two bytes queued
      push(0, 8'hC3); step();
      push(0, 8'h5A); step();
      push(0, 8'h0F); step();
      run(14);
      chk("pre_rst_count",  0, {5'd0, cnt[0]},    8'd2);
      chk("pre_rst_active", 0, {7'd0, active[0]}, 8'd1);
      b0 = obs_done[0];
      rst_l = 1'b0;
      step();
      rst_l = 1'b1;
      n_st = 0;
      chk("abort_serial", 0, {7'd0, ser[0]},    8'd1);
      chk("abort_count",  0, {5'd0, cnt[0]},    8'd0);
      chk("abort_active", 0, {7'd0, active[0]}, 8'd0);
      run(60);
      chk("abort_no_done",   0, 8'(obs_done[0] - b0), 8'd0);
      chk("abort_no_frames", 0, 8'(n_st), 8'd0);

      // Random traffic, occasionally bursty enough to overflow
      repeat (2000) begin
         for (int d = 0; d < 3; d++) begin
            if ($urandom_range(0, 299) == 0) burst[d] = 6;
            if (burst[d] > 0 || $urandom_range(0, 29) == 0) begin
               push(d, 8'($urandom));
               if (burst[d] > 0) burst[d]--;
            end
         end
         step();
      end
      run(300);
      for (int d = 0; d < 3; d++) begin
         chk("drain_active", d, {7'd0, active[d]}, 8'd0);
         chk("drain_count",  d, {5'd0, cnt[d]},    8'd0);
         chk("frame_total",  d, 8'(obs_done[d]),  8'(m_frames[d]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
